// File: rtl/alu_seq_pkg.sv
// Operation codes, flag layout and controller states shared by alu_seq and its bench.
// Codes 0-9 are the original combinational alu set; 10-12 are the sequential additions.
package alu_ops;

  typedef enum logic [3:0] {
    LL_SHIFT = 4'd0,
    LR_SHIFT = 4'd1,
    AL_SHIFT = 4'd2,
    AR_SHIFT = 4'd3,
    NOT_OP   = 4'd4,
    AND_OP   = 4'd5,
    OR_OP    = 4'd6,
    XOR_OP   = 4'd7,
    ADD_OP   = 4'd8,
    SUB_OP   = 4'd9,
    MUL_OP   = 4'd10,
    ADC_OP   = 4'd11,
    SBC_OP   = 4'd12
  } opcode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done/prod_* are combinational so the caller can load the product on the final step edge.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH:0]       psum;

  // acc = {partial high, unconsumed multiplier bits}; each step adds then shifts right
  always_comb begin
    psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {psum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc <= acc_nxt;
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done    = busy && (cnt == LAST);
  assign prod_lo = acc_nxt[WIDTH-1:0];
  assign prod_hi = acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, persistent NZCV flags and an iterative MUL.
// Single-cycle ops load on the accept edge; MUL runs WIDTH cycles with the input blocked.
module alu_seq
  import alu_ops::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags
);
  localparam int MSB = WIDTH - 1;

  opcode_t          op;
  state_t           state, state_nxt;
  flags_t           flags_q, r_f;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH:0]   sum, diff;
  logic             cc, r_c, r_v;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  assign op        = opcode_t'(opcode);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == MUL_OP);

  // Single-cycle datapath; ADC/SBC take the carry from the last loaded result
  always_comb begin
    cc   = (op == ADD_OP || op == SUB_OP) ? cin : flags_q.c;
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cc};
    diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cc};
    r_y  = '0;
    r_c  = 1'b0;
    r_v  = 1'b0;
    case (op)
      LL_SHIFT, AL_SHIFT: r_y = a << b;
      LR_SHIFT:           r_y = a >> b;
      AR_SHIFT:           r_y = $signed(a) >>> b;
      NOT_OP:             r_y = ~a;
      AND_OP:             r_y = a & b;
      OR_OP:              r_y = a | b;
      XOR_OP:             r_y = a ^ b;
      ADD_OP, ADC_OP: begin
        r_y = sum[MSB:0];
        r_c = sum[WIDTH];
        r_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      SUB_OP, SBC_OP: begin
        r_y = diff[MSB:0];
        r_c = diff[WIDTH];
        r_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default:            r_y = '0;
    endcase
    r_f = '{n: r_y[MSB], z: (r_y == '0), c: r_c, v: r_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (mul_start) state_nxt = MUL_RUN;
      end
      MUL_RUN: if (mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      y_hi      <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else if (state == MUL_RUN) begin
      if (mul_done) begin
        y         <= mul_lo;
        y_hi      <= mul_hi;
        flags_q   <= '{n: mul_lo[MSB], z: ({mul_hi, mul_lo} == '0), c: |mul_hi, v: 1'b0};
        out_valid <= 1'b1;
      end
    end else if (accept) begin
      if (op == MUL_OP) begin
        out_valid <= 1'b0;
      end else begin
        y         <= r_y;
        y_hi      <= '0;
        flags_q   <= r_f;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign flags = flags_q;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .prod_hi (mul_hi)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4: integer-arithmetic reference model checked every
// cycle, plus literal expectations on the key vectors.
module tb_alu_seq;
  import alu_ops::*;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic [3:0]   opcode, flags;
  logic [W-1:0] a, b, y, y_hi;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .y_hi(y_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {y_hi, y, N, Z, C, V} from plain integer arithmetic
  function automatic logic [2*W+3:0] ref_op(input logic [3:0] o, input int av, input int bv,
                                            input int ci, input int cst);
    int m, r, hi, c, v, z, sa, s, cc;
    m = 1 << W; r = 0; hi = 0; c = 0; v = 0; z = -1;
    cc = (o == ADD_OP || o == SUB_OP) ? ci : cst;
    sa = (av >= m / 2) ? av - m : av;
    case (o)
      LL_SHIFT, AL_SHIFT: r = (bv >= W) ? 0 : (av << bv) % m;
      LR_SHIFT: r = (bv >= W) ? 0 : av >> bv;
      AR_SHIFT: r = (bv >= W) ? ((sa < 0) ? m - 1 : 0) : ((sa >>> bv) & (m - 1));
      NOT_OP:   r = (m - 1) - av;
      AND_OP:   r = av & bv;
      OR_OP:    r = av | bv;
      XOR_OP:   r = av ^ bv;
      ADD_OP, ADC_OP: begin
        s = av + bv + cc; r = s % m; c = (s >= m) ? 1 : 0;
        v = ((av >= m/2) == (bv >= m/2) && (r >= m/2) != (av >= m/2)) ? 1 : 0;
      end
      SUB_OP, SBC_OP: begin
        s = av - bv - cc; r = (s + 2 * m) % m; c = (s < 0) ? 1 : 0;
        v = ((av >= m/2) != (bv >= m/2) && (r >= m/2) != (av >= m/2)) ? 1 : 0;
      end
      MUL_OP: begin
        s = av * bv; r = s % m; hi = s / m; c = (hi != 0) ? 1 : 0; z = (s == 0) ? 1 : 0;
      end
      default: r = 0;
    endcase
    if (z < 0) z = (r == 0) ? 1 : 0;
    return {hi[W-1:0], r[W-1:0], (r >= m / 2) ? 1'b1 : 1'b0, z[0], c[0], v[0]};
  endfunction

  logic           m_ov;
  int             m_busy;
  logic [W-1:0]   m_y, m_yhi;
  logic [3:0]     m_fl;
  logic [2*W+3:0] pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov <= 1'b0; m_busy <= 0; m_y <= '0; m_yhi <= '0; m_fl <= '0; pend <= '0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        {m_yhi, m_y, m_fl} <= pend;
        m_ov <= 1'b1;
      end
    end else if (in_valid && (!m_ov || out_ready)) begin
      if (opcode == MUL_OP) begin
        pend   <= ref_op(opcode, int'(a), int'(b), int'(cin), int'(m_fl[1]));
        m_busy <= W;
        m_ov   <= 1'b0;
      end else begin
        {m_yhi, m_y, m_fl} <= ref_op(opcode, int'(a), int'(b), int'(cin), int'(m_fl[1]));
        m_ov <= 1'b1;
      end
    end else if (out_ready) begin
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("in_ready", 32'(in_ready), 32'(m_busy == 0 && (!m_ov || out_ready)));
      if (m_ov) begin
        chk("y", 32'(y), 32'(m_y));
        chk("y_hi", 32'(y_hi), 32'(m_yhi));
        chk("flags", 32'(flags), 32'(m_fl));
      end
    end
  end

  // Each step starts just after a falling edge and ends on the next falling edge
  task automatic op(input logic [3:0] o, input int av, input int bv,
                    input logic ci = 1'b0, input logic ordy = 1'b1);
    #1;
    opcode = o; a = av[W-1:0]; b = bv[W-1:0]; cin = ci; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic nop(input logic ordy = 1'b1);
    #1;
    in_valid = 1'b0; out_ready = ordy;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst y", 32'(y), 0);
    chk("rst y_hi", 32'(y_hi), 0);
    chk("rst flags", 32'(flags), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    #1 rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    op(ADD_OP, 8, 7, 1'b1);
    chk("add8+7+1 y", 32'(y), 0);
    chk("add8+7+1 flags", 32'(flags), 32'b0110);
    op(SUB_OP, 8, 3, 1'b1);
    chk("sub8-3-1 y", 32'(y), 4);
    chk("sub8-3-1 flags", 32'(flags), 32'b0001);
    op(SBC_OP, 0, 0);
    chk("sbc0-0 y", 32'(y), 0);
    chk("sbc0-0 flags", 32'(flags), 32'b0100);
    op(ADD_OP, 15, 1);
    chk("add15+1 flags", 32'(flags), 32'b0110);
    op(ADC_OP, 0, 0);
    chk("adc0+0 y", 32'(y), 1);
    chk("adc0+0 flags", 32'(flags), 32'b0000);

    op(MUL_OP, 15, 15);
    nop();
    chk("mul busy in_ready", 32'(in_ready), 0);
    chk("mul busy out_valid", 32'(out_valid), 0);
    repeat (3) nop();
    chk("mul15x15 out_valid", 32'(out_valid), 1);
    chk("mul15x15 y", 32'(y), 1);
    chk("mul15x15 y_hi", 32'(y_hi), 14);
    chk("mul15x15 flags", 32'(flags), 32'b0010);

    op(AR_SHIFT, 9, 1);
    chk("ar 1001>>>1", 32'(y), 32'b1100);
    op(AR_SHIFT, 9, 9);
    chk("ar 1001>>>9", 32'(y), 32'b1111);
    op(LL_SHIFT, 1, 4);
    chk("ll 0001<<4 y", 32'(y), 0);
    chk("ll 0001<<4 flags", 32'(flags), 32'b0100);
    op(LR_SHIFT, 8, 2);
    op(AL_SHIFT, 3, 1);
    op(NOT_OP, 5, 0);
    op(XOR_OP, 5, 3);
    op(OR_OP, 9, 4);
    op(ADD_OP, 7, 1);
    chk("add7+1 flags", 32'(flags), 32'b1001);
    op(SUB_OP, 0, 8);
    op(4'd15, 6, 3);
    chk("undef y", 32'(y), 0);
    chk("undef flags", 32'(flags), 32'b0100);
    op(MUL_OP, 0, 9);
    repeat (W) nop();
    op(MUL_OP, 3, 5);
    repeat (W) nop();

    op(AND_OP, 12, 10);
    for (int i = 0; i < 3; i++) begin
      op(OR_OP, 1, 2, 1'b0, 1'b0);
      chk("stall y", 32'(y), 8);
      chk("stall flags", 32'(flags), 32'b1000);
      chk("stall in_ready", 32'(in_ready), 0);
    end
    nop();

    op(MUL_OP, 3, 5);
    nop();
    #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mulrst y", 32'(y), 0);
    chk("mulrst y_hi", 32'(y_hi), 0);
    chk("mulrst flags", 32'(flags), 0);
    chk("mulrst out_valid", 32'(out_valid), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (2 * W) nop();
    chk("mulrst no result", 32'(out_valid), 0);
    op(ADD_OP, 2, 3);
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
